fifo_reader: RTL and testbench

Read-side controller for the 8-entry, 4-bit FIFO with almost-empty/almost-full gating. It decides when to assert the FIFO's read enable, captures the returned word, and forwards it downstream with a valid strobe. It throttles on a downstream occupancy threshold that is loaded at initialisation. It sits between a FIFO's read port and the next stage (arbiter or demux) in the datapath.

---
 rtl/fifo_reader_pkg.sv | 13 +
 rtl/fifo_reader_pipe.sv | 29 ++
 rtl/fifo_reader.sv | 95 +++++++++
 tb/tb_fifo_reader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared encodings and widths for the fifo_reader read-side controller.
package fifo_reader_pkg;
   localparam int DATA_W = 4;
   localparam int CNT_W  = 4;
   localparam int STAT_W = 8;

   typedef enum logic [1:0] {
      RESET  = 2'd0,
      INIT   = 2'd1,
      IDLE   = 2'd2,
      ACTIVE = 2'd3
   } state_t;
endpackage

// File: rtl/fifo_reader_pipe.sv
// Two-stage return path: read strobe delay, then capture of the FIFO word.
// Also reports how many issued reads have not yet reached valid_out.
module fifo_reader_pipe
   import fifo_reader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              rd_q,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic [1:0]        inflight
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q      <= 1'b0;
         valid_out <= 1'b0;
         data_out  <= '0;
      end else begin
         rd_q      <= rd_en;
         valid_out <= rd_q;
         if (rd_q) data_out <= fifo_data;
      end
   end

   // valid_out mirrors rd_en from two cycles back, so it doubles as the older in-flight bit
   assign inflight = {1'b0, rd_q} + {1'b0, valid_out};
endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the 8-entry FIFO: FSM, pause threshold and read gating.
// Define FIFO_READER_STATS_EN to build the delivered-word counter on rd_count.
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int LOW_WM    = 2,
   parameter int PAUSE_THR = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic [CNT_W-1:0]  thr_in,
   input  logic [CNT_W-1:0]  fifo_count,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic [CNT_W-1:0]  down_count,
   output logic              rd_en,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              idle,
   output logic [1:0]        state_out,
   output logic [STAT_W-1:0] rd_count
);
   localparam logic [CNT_W-1:0] LOW_WM_C    = LOW_WM[CNT_W-1:0];
   localparam logic [CNT_W-1:0] PAUSE_THR_C = PAUSE_THR[CNT_W-1:0];

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  thr;
   logic              rd_q;
   logic [1:0]        inflight;
   logic [CNT_W:0]    load;
   logic              pause;
   logic              above_wm;

   assign above_wm = fifo_count > LOW_WM_C;
   // 5-bit sum: down_count up to 15 plus two in-flight reads cannot wrap
   assign load     = {1'b0, down_count} + {3'b000, inflight};
   assign pause    = load >= {1'b0, thr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RESET;
         thr   <= PAUSE_THR_C;
      end else begin
         state <= state_nxt;
         if (state == INIT) thr <= thr_in;
      end
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      case (state)
         RESET:  if (init) state_nxt = INIT;
         INIT:   if (!init) state_nxt = IDLE;
         IDLE: begin
            if (init)          state_nxt = INIT;
            else if (above_wm) state_nxt = ACTIVE;
         end
         ACTIVE: begin
            rd_en = above_wm && !pause;
            if (init)           state_nxt = INIT;
            else if (!above_wm) state_nxt = IDLE;
         end
         default: state_nxt = RESET;
      endcase
   end

   fifo_reader_pipe u_pipe (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .fifo_data (fifo_data),
      .rd_q      (rd_q),
      .data_out  (data_out),
      .valid_out (valid_out),
      .inflight  (inflight)
   );

   assign idle      = (state == IDLE) && !rd_q && !valid_out;
   assign state_out = state;

`ifdef FIFO_READER_STATS_EN
   logic [STAT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 cnt <= '0;
      else if (state == INIT)  cnt <= '0;
      else if (valid_out)      cnt <= cnt + 1'b1;
   end

   assign rd_count = cnt;
`else
   assign rd_count = '0;
`endif
endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: cycle model for control outputs and a
// scoreboard queue of words returned by a behavioural FIFO.
module tb_fifo_reader;
   logic       clk = 1'b0;
   logic       rst, init;
   logic [3:0] thr_in, fifo_count, fifo_data, down_count;
   logic       rd_en, valid_out, idle;
   logic [3:0] data_out;
   logic [1:0] state_out;
   logic [7:0] rd_count;

   fifo_reader #(.LOW_WM(2), .PAUSE_THR(6)) dut (
      .clk(clk), .rst(rst), .init(init), .thr_in(thr_in),
      .fifo_count(fifo_count), .fifo_data(fifo_data), .down_count(down_count),
      .rd_en(rd_en), .data_out(data_out), .valid_out(valid_out), .idle(idle),
      .state_out(state_out), .rd_count(rd_count)
   );

   always #5 clk = ~clk;

   int errs = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // reference model state
   int         ms;
   int         mthr;
   bit         mrdq, mvalid, last_rd, refill;
   logic [7:0] mcnt;
   int         fcnt;
   logic [3:0] q[$];

   function automatic logic [7:0] exp_cnt();
`ifdef FIFO_READER_STATS_EN
      return mcnt;
`else
      return 8'd0;
`endif
   endfunction

   task automatic model_reset();
      ms = 0; mthr = 6; mrdq = 0; mvalid = 0; mcnt = 0; last_rd = 0;
      q.delete();
   endtask

   task automatic cyc();
      bit mre, midle;
      int nms;
      #1;
      mre   = (ms == 3) && (fcnt > 2) &&
              !((int'(down_count) + int'(mrdq) + int'(mvalid)) >= mthr);
      midle = (ms == 2) && !mrdq && !mvalid;
      chk("state", 32'(state_out), 32'(ms));
      chk("rd_en", 32'(rd_en), 32'(mre));
      chk("valid", 32'(valid_out), 32'(mvalid));
      chk("idle", 32'(idle), 32'(midle));
      chk("rd_count", 32'(rd_count), 32'(exp_cnt()));
      if (valid_out) begin
         if (q.size() == 0) chk("sb_empty", 32'(1), 32'(0));
         else               chk("data", 32'(data_out), 32'(q.pop_front()));
      end
      case (ms)
         0: nms = init ? 1 : 0;
         1: nms = init ? 1 : 2;
         2: nms = init ? 1 : (fcnt > 2 ? 3 : 2);
         default: nms = init ? 1 : (fcnt <= 2 ? 2 : 3);
      endcase
      if (ms == 1)     mcnt = 8'd0;
      else if (mvalid) mcnt = mcnt + 8'd1;
      if (ms == 1) mthr = int'(thr_in);
      mvalid  = mrdq;
      mrdq    = mre;
      last_rd = mre;
      ms      = nms;
      @(posedge clk);
      #1;
      if (last_rd) begin
         fifo_data = 4'($urandom);
         q.push_back(fifo_data);
         if (fcnt > 0) fcnt--;
      end
      if (refill) fcnt = 8;
      fifo_count = 4'(fcnt);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic set_fifo(input int n);
      fcnt = n;
      fifo_count = 4'(n);
   endtask

   task automatic do_init(input logic [3:0] t);
      thr_in = t; init = 1'b1;
      run(2);
      init = 1'b0;
   endtask

   initial begin
      bit seen;
      rst = 1'b1; init = 1'b0; thr_in = 4'd0; down_count = 4'd0;
      fifo_data = 4'd0; refill = 0; set_fifo(0);
      model_reset();
      #2;
      chk("rst_state", 32'(state_out), 32'(0));
      chk("rst_rd_en", 32'(rd_en), 32'(0));
      chk("rst_valid", 32'(valid_out), 32'(0));
      chk("rst_data", 32'(data_out), 32'(0));
      chk("rst_idle", 32'(idle), 32'(0));
      chk("rst_count", 32'(rd_count), 32'(0));
      @(posedge clk); #1; rst = 1'b0;

      // reset -> INIT -> IDLE with an empty FIFO
      run(2);
      do_init(4'd5);
      run(3);
      chk("idle_reached", 32'(idle), 32'(1));

      // three reads from count 5, then back to IDLE
      set_fifo(5);
      run(8);

      // threshold 4 with downstream at 3, then 2
      do_init(4'd4);
      down_count = 4'd3; set_fifo(8);
      run(8);
      down_count = 4'd2;
      run(8);

      // thr = 0 never reads
      do_init(4'd0);
      down_count = 4'd0; set_fifo(8);
      run(6);

      // thr = 11 never pauses, even with a full downstream
      do_init(4'd11);
      down_count = 4'd8; set_fifo(8);
      run(10);

      // init while a word is in flight
      do_init(4'd15);
      down_count = 4'd0; set_fifo(8);
      run(3);
      init = 1'b1; run(2);
      init = 1'b0; run(4);

      // asynchronous reset the cycle after a read
      set_fifo(3);
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         cyc();
         seen = last_rd;
      end
      chk("rd_before_rst", 32'(seen), 32'(1));
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(valid_out), 32'(0));
      chk("mid_rst_data", 32'(data_out), 32'(0));
      chk("mid_rst_state", 32'(state_out), 32'(0));
      chk("mid_rst_rd_en", 32'(rd_en), 32'(0));
      model_reset();
      @(posedge clk); #1;
      chk("post_rst_valid", 32'(valid_out), 32'(0));
      rst = 1'b0;
      run(3);

      // randomised traffic
      do_init(4'd6);
      for (int i = 0; i < 300; i++) begin
         down_count = 4'($urandom_range(0, 8));
         init       = ($urandom_range(0, 40) == 0);
         thr_in     = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0 && fcnt < 8) set_fifo(fcnt + 1);
         cyc();
      end
      init = 1'b0;

      // sustained stream for counter wrap
      do_init(4'd15);
      down_count = 4'd0; refill = 1; set_fifo(8);
      run(262);
      refill = 0;
      run(2);
`ifdef FIFO_READER_STATS_EN
      chk("wrap_count", 32'(rd_count), 32'(8'd4));
`else
      chk("nostats_count", 32'(rd_count), 32'(0));
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
